// File: rtl/sram_burst_ctrl_if.sv
// Bus bundle between a command/stream master and sram_burst_ctrl, plus the SRAM pin group.
// Latency: none (wires only).
// Backpressure: cmd and write streams use valid/ready; the read stream uses out_valid/out_ready.
//
// Ports (signals):
//   cmd_*   : command offer (valid/ready), direction, base address, length
//   in_*    : write-data stream into the controller
//   out_*   : read-data stream out of the controller
//   done    : one-cycle burst completion pulse
//   sram_*  : CEN/WEN/A/D driven to the SRAM, Q returned from it
interface sram_burst_ctrl_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 12
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              done;
   logic              sram_CEN;
   logic              sram_WEN;
   logic [ADDR_W-1:0] sram_A;
   logic [DATA_W-1:0] sram_D;
   logic [DATA_W-1:0] sram_Q;

   // Command/stream source and SRAM model side.
   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_len,
      output in_valid, in_data, out_ready, sram_Q,
      input  cmd_ready, in_ready, out_valid, out_data, done,
      input  sram_CEN, sram_WEN, sram_A, sram_D
   );

   // Controller side.
   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len,
      input  in_valid, in_data, out_ready, sram_Q,
      output cmd_ready, in_ready, out_valid, out_data, done,
      output sram_CEN, sram_WEN, sram_A, sram_D
   );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Burst engine: turns (addr, len, dir) commands into sequential SRAM writes/reads.
// Latency: writes issue combinationally with in_valid; first read word on out_valid 2 cycles after accept.
// Backpressure: in_ready is high throughout WR; reads throttle so FIFO occupancy + in-flight never exceeds 2.
//
// Ports: CLK, RESET_N (async active-low), bus (sram_burst_ctrl_if.slave: cmd_*, in_*, out_*, done, sram_*).
// Optional: define SRAM_CTRL_STALL_CNT_EN to add output stall_cnt[15:0] (saturating stall-cycle counter).
module sram_burst_ctrl #(
   parameter int NUM    = 2048,
   parameter int DATA_W = 32,
   parameter int LEN_W  = $clog2(NUM) + 1
) (
   input  logic              CLK,
   input  logic              RESET_N,
   sram_burst_ctrl_if.slave  bus
`ifdef SRAM_CTRL_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);
   localparam int ADDR_W = $clog2(NUM);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_base;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_idx;        // words issued so far in this burst
   logic              r_inflight;   // a read was issued last cycle; its Q is valid now
   logic [DATA_W-1:0] r_fifo [2];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_occ;

   logic              w_accept;
   logic              w_wr_issue;
   logic              w_rd_issue;
   logic              w_last;
   logic              w_push;
   logic              w_pop;
   logic              w_cmd_ready;
   logic              w_in_ready;
   logic [2:0]        w_pending;

   assign w_last    = (r_idx == (r_len - LEN_W'(1)));
   assign w_push    = r_inflight;
   assign w_pop     = (r_occ != 2'd0) && bus.out_ready;
   assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight};

   // Direction is not stored separately: the WR/RD state chosen at accept carries it.
   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      w_wr_issue  = 1'b0;
      w_rd_issue  = 1'b0;
      w_cmd_ready = 1'b0;
      w_in_ready  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               w_accept = 1'b1;
               if (bus.cmd_len == '0)
                  w_next = S_DONE;
               else if (bus.cmd_write)
                  w_next = S_WR;
               else
                  w_next = S_RD;
            end
         end
         S_WR: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_wr_issue = 1'b1;
               if (w_last)
                  w_next = S_DONE;
            end
         end
         S_RD: begin
            // A pop this cycle frees a slot, so issuing keeps the total at 2.
            if ((w_pending < 3'd2) || w_pop) begin
               w_rd_issue = 1'b1;
               if (w_last)
                  w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!r_inflight && (r_occ == 2'd0))
               w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_len      <= '0;
         r_idx      <= '0;
         r_inflight <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_occ      <= 2'd0;
         for (int i = 0; i < 2; i++)
            r_fifo[i] <= '0;
      end else begin
         r_state    <= w_next;
         r_inflight <= w_rd_issue;
         if (w_accept) begin
            r_base <= bus.cmd_addr;
            r_len  <= bus.cmd_len;
            r_idx  <= '0;
         end else if (w_wr_issue || w_rd_issue) begin
            r_idx  <= r_idx + LEN_W'(1);
         end
         if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.sram_Q;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign bus.cmd_ready = w_cmd_ready;
   assign bus.in_ready  = w_in_ready;
   assign bus.done      = (r_state == S_DONE);
   assign bus.out_valid = (r_occ != 2'd0);
   assign bus.out_data  = r_fifo[r_rd_ptr];
   assign bus.sram_CEN  = !(w_wr_issue || w_rd_issue);
   assign bus.sram_WEN  = !w_wr_issue;
   // Address wraps naturally at 2^ADDR_W.
   assign bus.sram_A    = r_base + r_idx[ADDR_W-1:0];
   assign bus.sram_D    = w_wr_issue ? bus.in_data : '0;

`ifdef SRAM_CTRL_STALL_CNT_EN
   logic [15:0] r_stall_cnt;
   logic        w_stall;

   assign w_stall = (((r_state == S_RD) || (r_state == S_DRAIN)) && (r_occ != 2'd0) && !bus.out_ready)
                  || ((r_state == S_WR) && !bus.in_valid);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         r_stall_cnt <= 16'd0;
      else if (w_accept)
         r_stall_cnt <= 16'd0;
      else if (w_stall && (r_stall_cnt != 16'hFFFF))
         r_stall_cnt <= r_stall_cnt + 16'd1;
   end

   assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Testbench for sram_burst_ctrl: SRAM model, transaction-level reference memory, directed bursts.
// Latency: n/a.
// Backpressure: out_ready driven as held-low, held-high or a 1,0,0,1 repeating pattern.
module tb_sram_burst_ctrl;
   localparam int NUM    = 2048;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 12;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } acc_t;

   logic CLK = 1'b0;
   logic RESET_N = 1'b0;
   always #5 CLK = ~CLK;

   sram_burst_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();
`ifdef SRAM_CTRL_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   sram_burst_ctrl #(.NUM(NUM), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus)
`ifdef SRAM_CTRL_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   // SRAM word array with one-cycle read latency.
   logic [DATA_W-1:0] mem [NUM];
   always @(posedge CLK) begin
      if (!bus.sram_CEN) begin
         if (!bus.sram_WEN) mem[bus.sram_A] <= bus.sram_D;
         else               bus.sram_Q      <= mem[bus.sram_A];
      end
   end

   // Reference model: intended memory contents and the expected access / read-data streams.
   logic [DATA_W-1:0] ref_mem [NUM];
   acc_t              exp_acc[$];
   logic [DATA_W-1:0] exp_rd[$];
   int                n_rd_out = 0;  // reads issued but not yet consumed downstream

   // Observation logs for the directed checks.
   int                cen_cyc[$];
   logic [ADDR_W-1:0] cen_a[$];
   int                pop_cyc[$];
   logic [DATA_W-1:0] pop_dat[$];
   int                done_cyc[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rdy_mode = 1;     // 0 = low, 1 = high, 2 = 1,0,0,1 pattern
   logic [3:0] rdy_pat = 4'b1001;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(posedge CLK) begin
      #1;
      case (rdy_mode)
         0:       bus.out_ready = 1'b0;
         1:       bus.out_ready = 1'b1;
         default: bus.out_ready = rdy_pat[cyc % 4];
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Compare process: every SRAM access and every downstream pop is checked against the model.
   always @(negedge CLK) begin
      acc_t e;
      if (!RESET_N) begin
         n_rd_out = 0;
      end else begin
         if (!bus.sram_CEN) begin
            cen_cyc.push_back(cyc);
            cen_a.push_back(bus.sram_A);
            if (exp_acc.size() == 0) begin
               fail("unexpected_sram_access");
            end else begin
               e = exp_acc.pop_front();
               chk("acc_wen", 64'(bus.sram_WEN), 64'(!e.wr));
               chk("acc_addr", 64'(bus.sram_A), 64'(e.a));
               if (e.wr) chk("acc_data", 64'(bus.sram_D), 64'(e.d));
            end
            if (bus.sram_WEN) n_rd_out++;
         end
         if (bus.out_valid && bus.out_ready) begin
            pop_cyc.push_back(cyc);
            pop_dat.push_back(bus.out_data);
            n_rd_out--;
            if (exp_rd.size() == 0) fail("unexpected_out_word");
            else chk("out_data", 64'(bus.out_data), 64'(exp_rd.pop_front()));
         end
         if (!bus.sram_CEN || (bus.out_valid && bus.out_ready))
            chk("reads_outstanding_le2", 64'(n_rd_out <= 2), 64'(1));
         if (bus.done) begin
            done_cyc.push_back(cyc);
            chk("done_after_all_work", 64'(exp_acc.size() + exp_rd.size()), 64'(0));
         end
      end
   end

   task automatic clr_logs();
      cen_cyc.delete(); cen_a.delete(); pop_cyc.delete(); pop_dat.delete(); done_cyc.delete();
   endtask

   // Offers a command; returns acc = cycle index of the first cycle after the accepting edge.
   task automatic do_cmd(input logic wr, input logic [ADDR_W-1:0] addr, input int len, output int acc);
      int n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_len   = LEN_W'(len);
      do begin
         @(negedge CLK);
         n++;
      end while (!bus.cmd_ready && n < 50);
      if (!bus.cmd_ready) begin
         fail("cmd_accept_timeout");
         acc = -1;
      end else begin
         @(posedge CLK);
         #1;
         acc = cyc;
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wr_burst(input logic [ADDR_W-1:0] addr, input int len, input logic [DATA_W-1:0] d0,
                           input bit gap, output int acc);
      for (int k = 0; k < len; k++) begin
         ref_mem[addr + ADDR_W'(k)] = d0 + DATA_W'(k);
         exp_acc.push_back('{wr: 1'b1, a: addr + ADDR_W'(k), d: d0 + DATA_W'(k)});
      end
      do_cmd(1'b1, addr, len, acc);
      for (int k = 0; k < len; k++) begin
         if (gap && k > 0) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 32'hBAD0_0000;
            @(posedge CLK); #1;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = d0 + DATA_W'(k);
         @(posedge CLK); #1;
      end
      bus.in_valid = 1'b0;
      bus.in_data  = 32'hBAD0_0001;
   endtask

   task automatic rd_burst(input logic [ADDR_W-1:0] addr, input int len, output int acc);
      for (int k = 0; k < len; k++) begin
         exp_acc.push_back('{wr: 1'b0, a: addr + ADDR_W'(k), d: '0});
         exp_rd.push_back(ref_mem[addr + ADDR_W'(k)]);
      end
      do_cmd(1'b0, addr, len, acc);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cyc.size() == 0 && n < budget) begin
         @(negedge CLK); #1;
         n++;
      end
      if (done_cyc.size() == 0) fail("done_timeout");
      repeat (2) @(posedge CLK);
      #1;
   endtask

   initial begin
      int acc;
      int n;
      for (int i = 0; i < NUM; i++) ref_mem[i] = '0;
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
      bus.in_valid  = 1'b0; bus.in_data   = '0;

      // Reset state
      #12;
      chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_done", 64'(bus.done), 64'(0));
      chk("rst_cen", 64'(bus.sram_CEN), 64'(1));
      chk("rst_wen", 64'(bus.sram_WEN), 64'(1));
      chk("rst_a", 64'(bus.sram_A), 64'(0));
      chk("rst_d", 64'(bus.sram_D), 64'(0));
      @(negedge CLK); RESET_N = 1'b1;
      @(posedge CLK); #1;

      // Write 0x010 len 4, continuous data
      clr_logs();
      wr_burst(11'h010, 4, 32'hA0, 1'b0, acc);
      wait_done(40);
      chk("wr_cen_count", 64'(cen_cyc.size()), 64'(4));
      for (int i = 0; i < 4 && i < cen_cyc.size(); i++) begin
         chk("wr_cen_cycle", 64'(cen_cyc[i]), 64'(acc + i));
         chk("wr_addr_lit", 64'(cen_a[i]), 64'(32'h10 + i));
      end
      chk("wr_done_count", 64'(done_cyc.size()), 64'(1));
      if (done_cyc.size() > 0) chk("wr_done_cycle", 64'(done_cyc[0]), 64'(acc + 4));

      // Read back 0x010 len 4, out_ready high
      clr_logs();
      rdy_mode = 1;
      rd_burst(11'h010, 4, acc);
      wait_done(40);
      chk("rd_pop_count", 64'(pop_cyc.size()), 64'(4));
      for (int i = 0; i < 4 && i < pop_cyc.size(); i++) begin
         chk("rd_pop_cycle", 64'(pop_cyc[i]), 64'(acc + 2 + i));
         chk("rd_data_lit", 64'(pop_dat[i]), 64'(32'hA0 + i));
      end
      chk("rd_done_count", 64'(done_cyc.size()), 64'(1));
      if (done_cyc.size() > 0 && pop_cyc.size() == 4)
         chk("rd_done_after_pop", 64'(done_cyc[0] > pop_cyc[3]), 64'(1));

      // Write 0x020 len 6 with a one-cycle gap between words
      clr_logs();
      wr_burst(11'h020, 6, 32'hC0, 1'b1, acc);
      wait_done(60);
      chk("gap_cen_count", 64'(cen_cyc.size()), 64'(6));
      for (int i = 0; i < 6 && i < cen_cyc.size(); i++)
         chk("gap_cen_cycle", 64'(cen_cyc[i]), 64'(acc + 2 * i));
      if (done_cyc.size() > 0) chk("gap_done_cycle", 64'(done_cyc[0]), 64'(acc + 11));

      // Read 0x020 len 6 with out_ready toggling 1,0,0,1
      clr_logs();
      rdy_mode = 2;
      rd_burst(11'h020, 6, acc);
      wait_done(80);
      chk("tog_pop_count", 64'(pop_dat.size()), 64'(6));
      for (int i = 0; i < 6 && i < pop_dat.size(); i++)
         chk("tog_data_lit", 64'(pop_dat[i]), 64'(32'hC0 + i));
      chk("tog_done_count", 64'(done_cyc.size()), 64'(1));

      // Address wrap at the top of the array
      clr_logs();
      rdy_mode = 1;
      wr_burst(11'h7FE, 4, 32'hB0, 1'b0, acc);
      wait_done(40);
      chk("wrap_cen_count", 64'(cen_a.size()), 64'(4));
      if (cen_a.size() == 4) begin
         chk("wrap_a0", 64'(cen_a[0]), 64'h7FE);
         chk("wrap_a1", 64'(cen_a[1]), 64'h7FF);
         chk("wrap_a2", 64'(cen_a[2]), 64'h000);
         chk("wrap_a3", 64'(cen_a[3]), 64'h001);
      end
      clr_logs();
      rd_burst(11'h7FE, 4, acc);
      wait_done(40);
      for (int i = 0; i < 4 && i < pop_dat.size(); i++)
         chk("wrap_rd_lit", 64'(pop_dat[i]), 64'(32'hB0 + i));

      // Empty burst
      clr_logs();
      do_cmd(1'b0, 11'h100, 0, acc);
      @(negedge CLK);
      chk("len0_done", 64'(bus.done), 64'(1));
      chk("len0_ready_in_done", 64'(bus.cmd_ready), 64'(0));
      @(negedge CLK);
      chk("len0_ready_back", 64'(bus.cmd_ready), 64'(1));
      chk("len0_done_low", 64'(bus.done), 64'(0));
      repeat (2) @(negedge CLK);
      chk("len0_no_cen", 64'(cen_cyc.size()), 64'(0));
      chk("len0_done_count", 64'(done_cyc.size()), 64'(1));
      if (done_cyc.size() > 0) chk("len0_done_cycle", 64'(done_cyc[0]), 64'(acc));
      @(posedge CLK); #1;

      // Reset in the middle of a read burst after two issues
      clr_logs();
      rdy_mode = 0;
      rd_burst(11'h010, 6, acc);
      n = 0;
      while (cen_cyc.size() < 2 && n < 20) begin
         @(negedge CLK); #1;
         n++;
      end
      if (cen_cyc.size() < 2) fail("mid_rst_issue_timeout");
      RESET_N = 1'b0;
      #1;
      chk("mid_rst_cen", 64'(bus.sram_CEN), 64'(1));
      chk("mid_rst_wen", 64'(bus.sram_WEN), 64'(1));
      chk("mid_rst_a", 64'(bus.sram_A), 64'(0));
      chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("mid_rst_done", 64'(bus.done), 64'(0));
      exp_acc.delete();
      exp_rd.delete();
      repeat (2) @(posedge CLK);
      @(negedge CLK); RESET_N = 1'b1;
      rdy_mode = 1;
      repeat (4) @(posedge CLK);
      #1;
      chk("mid_rst_no_done", 64'(done_cyc.size()), 64'(0));
      chk("mid_rst_no_pop", 64'(pop_cyc.size()), 64'(0));
      clr_logs();
      wr_burst(11'h040, 2, 32'hD0, 1'b0, acc);
      wait_done(40);
      chk("post_rst_done_count", 64'(done_cyc.size()), 64'(1));
      clr_logs();
      rd_burst(11'h040, 2, acc);
      wait_done(40);
      chk("post_rst_pop_count", 64'(pop_dat.size()), 64'(2));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit reached");
   end
endmodule
